// File: rtl/makestuff_chunk_arbiter.sv
// makestuff_chunk_arbiter: round-robin arbiter that hands a FIFO's write port to
// one requester at a time, in whole chunks of CHUNKSIZE beats.
// Ports: clk_in/reset_in (async, active-low); rData_in/rValid_in/rValidChunk_in
// and rReady_out per requester; oData_out/oValid_out/oReady_in/oReadyChunk_in
// toward the FIFO; grant_out, busy_out, chunkDone_out status.
// Optional: define MAKESTUFF_CHUNK_ARBITER_STATS_EN to add stats_out, one
// saturating 32-bit completed-chunk counter per requester.
module makestuff_chunk_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NUM_REQ   = 4,
    parameter int CHUNKSIZE = 4,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     clk_in,
    input  logic                     reset_in,
    input  logic [NUM_REQ*WIDTH-1:0] rData_in,
    input  logic [NUM_REQ-1:0]       rValid_in,
    input  logic [NUM_REQ-1:0]       rValidChunk_in,
    output logic [NUM_REQ-1:0]       rReady_out,
    output logic [WIDTH-1:0]         oData_out,
    output logic                     oValid_out,
    input  logic                     oReady_in,
    input  logic                     oReadyChunk_in,
    output logic [GW-1:0]            grant_out,
    output logic                     busy_out,
    output logic                     chunkDone_out
`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
    ,
    output logic [NUM_REQ*32-1:0]    stats_out
`endif
);

    localparam int CW = $clog2(CHUNKSIZE + 1);
    localparam logic [CW-1:0] LAST = CW'(CHUNKSIZE - 1);
    localparam logic [GW-1:0] MAXG = GW'(NUM_REQ - 1);

    typedef enum logic {IDLE, XFER} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [GW-1:0]    ptr;
    logic [GW-1:0]    grant;
    logic [GW-1:0]    win;
    logic [CW-1:0]    count;
    logic             arb;
    logic             beat;
    logic             last;
    logic             found;
    int               idx;
    logic [WIDTH-1:0] lane [NUM_REQ];

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
        assign lane[k] = rData_in[k*WIDTH +: WIDTH];
    end

    // First eligible requester at or after ptr, wrapping at NUM_REQ
    // (explicit subtract keeps non-power-of-2 counts correct).
    always_comb begin
        win   = ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && rValidChunk_in[idx]) begin
                found = 1'b1;
                win   = GW'(idx);
            end
        end
    end

    assign arb  = (state == IDLE) && oReadyChunk_in && (|rValidChunk_in);
    assign beat = (state == XFER) && rValid_in[grant] && oReady_in;
    assign last = beat && (count == LAST);

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (arb)  state_nxt = XFER;
            XFER: if (last) state_nxt = IDLE;
            default:        state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_out      = (state == XFER);
        oData_out     = lane[grant];
        oValid_out    = 1'b0;
        rReady_out    = '0;
        chunkDone_out = last;
        if (state == XFER) begin
            oValid_out        = rValid_in[grant];
            rReady_out[grant] = oReady_in;
        end
    end

    assign grant_out = grant;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ptr   <= '0;
            grant <= '0;
            count <= '0;
        end else if (arb) begin
            grant <= win;
            count <= '0;
        end else if (last) begin
            count <= '0;
            ptr   <= (grant == MAXG) ? '0 : grant + 1'b1;
        end else if (beat) begin
            count <= count + 1'b1;
        end
    end

`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
    logic [NUM_REQ-1:0][31:0] stats_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            stats_q <= '0;
        end else if (last && (stats_q[grant] != 32'hFFFF_FFFF)) begin
            stats_q[grant] <= stats_q[grant] + 32'd1;
        end
    end

    assign stats_out = stats_q;
`endif

endmodule

// File: tb/tb_makestuff_chunk_arbiter.sv
// tb_makestuff_chunk_arbiter: randomized and directed bench for the chunk
// arbiter with a transaction-level model of grants, beats and data order.
module tb_makestuff_chunk_arbiter;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int CS = 4;
    localparam int W3 = 8;
    localparam int N3 = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N*W-1:0] rdata;
    logic [N-1:0]   rvalid, rvc, rready;
    logic [W-1:0]   odata;
    logic           ovalid, ordy, ordyc, busy, done;
    logic [1:0]     grant;

    logic [N3*W3-1:0] rdata3;
    logic [N3-1:0]    rvalid3, rvc3, rready3;
    logic [W3-1:0]    odata3;
    logic             ovalid3, ordy3, ordyc3, busy3, done3;
    logic [1:0]       grant3;

`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
    logic [N*32-1:0]  stats;
    logic [N3*32-1:0] stats3;
`endif

    makestuff_chunk_arbiter #(.WIDTH(W), .NUM_REQ(N), .CHUNKSIZE(CS)) dut (
        .clk_in(clk), .reset_in(rst_n),
        .rData_in(rdata), .rValid_in(rvalid), .rValidChunk_in(rvc),
        .rReady_out(rready), .oData_out(odata), .oValid_out(ovalid),
        .oReady_in(ordy), .oReadyChunk_in(ordyc), .grant_out(grant),
        .busy_out(busy), .chunkDone_out(done)
`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
        , .stats_out(stats)
`endif
    );

    makestuff_chunk_arbiter #(.WIDTH(W3), .NUM_REQ(N3), .CHUNKSIZE(1)) dut3 (
        .clk_in(clk), .reset_in(rst_n),
        .rData_in(rdata3), .rValid_in(rvalid3), .rValidChunk_in(rvc3),
        .rReady_out(rready3), .oData_out(odata3), .oValid_out(ovalid3),
        .oReady_in(ordy3), .oReadyChunk_in(ordyc3), .grant_out(grant3),
        .busy_out(busy3), .chunkDone_out(done3)
`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
        , .stats_out(stats3)
`endif
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Transaction model: who owns the FIFO, beats taken so far, next pointer.
    bit m_busy = 0;
    int m_g = 0;
    int m_cnt = 0;
    int m_ptr = 0;
    int seq [N];
    int chunks [N];

    logic [N-1:0] last_rready;
    logic         last_done, last_busy;
    logic [1:0]   last_grant;
    int done_q[$];
    int gnt_q[$];

    task automatic set_data();
        for (int k = 0; k < N; k++)
            rdata[k*W +: W] = {8'(k), 24'(seq[k])};
    endtask

    // One clock of the main DUT: entered just after a rising edge,
    // checks mid-cycle, advances the model, returns after the next edge.
    task automatic step(input string tag);
        logic [N-1:0] er;
        logic ev, ed, bt;
        logic [W-1:0] ed_data;
        int k;
        cyc++;
        set_data();
        #1;
        er = '0;
        if (m_busy) er[m_g] = ordy;
        ev = m_busy && rvalid[m_g];
        bt = ev && ordy;
        ed = bt && (m_cnt == CS - 1);
        ed_data = {8'(m_g), 24'(seq[m_g])};
        last_rready = rready;
        last_done = done;
        last_busy = busy;
        last_grant = grant;
        if (done === 1'b1) begin
            done_q.push_back(cyc);
            gnt_q.push_back(int'(grant));
        end
        checks++;
        if (busy !== m_busy || grant !== 2'(m_g) || rready !== er ||
            ovalid !== ev || done !== ed || (ev && odata !== ed_data)) begin
            errors++;
            $display("FAIL %s cyc%0d got/exp busy %b/%b grant %0d/%0d rdy %b/%b vld %b/%b done %b/%b data %h/%h",
                     tag, cyc, busy, m_busy, grant, m_g, rready, er,
                     ovalid, ev, done, ed, odata, ed_data);
        end
        if (!m_busy) begin
            if (ordyc && rvc != 0) begin
                for (int i = 0; i < N; i++) begin
                    k = (m_ptr + i) % N;
                    if (rvc[k]) begin
                        m_g = k;
                        break;
                    end
                end
                m_busy = 1;
                m_cnt = 0;
            end
        end else if (bt) begin
            seq[m_g]++;
            m_cnt++;
            if (m_cnt == CS) begin
                m_busy = 0;
                m_ptr = (m_g + 1) % N;
                chunks[m_g]++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        rvc = '0; rvalid = '1; ordy = 1'b1;
        while (m_busy && n < 20) begin
            step("drain");
            n++;
        end
        checks++;
        if (m_busy) begin
            errors++;
            $display("FAIL drain_timeout cnt %0d required 0 pending", m_cnt);
        end
    endtask

    task automatic test_reset();
        #2;
        checks++;
        if (busy !== 0 || rready !== 0 || ovalid !== 0 || done !== 0 || grant !== 0) begin
            errors++;
            $display("FAIL reset_outputs busy %b rdy %b vld %b done %b grant %0d required zeros",
                     busy, rready, ovalid, done, grant);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rvc = '0; rvalid = '1; ordy = 1'b1; ordyc = 1'b1;
        for (int i = 0; i < 20; i++) step("idle");
    endtask

    task automatic test_round_robin();
        int start;
        rvalid = '1; rvc = '1; ordy = 1'b1; ordyc = 1'b1;
        done_q.delete();
        gnt_q.delete();
        start = cyc;
        for (int i = 0; i < 27; i++) step("rr");
        checks++;
        if (done_q.size() < 5) begin
            errors++;
            $display("FAIL rr_done_count got %0d required >=5", done_q.size());
        end else begin
            for (int j = 0; j < 5; j++) begin
                checks++;
                if (done_q[j] - start != 5 + 5*j || gnt_q[j] != j % 4) begin
                    errors++;
                    $display("FAIL rr_chunk%0d cycle %0d grant %0d required cycle %0d grant %0d",
                             j, done_q[j] - start, gnt_q[j], 5 + 5*j, j % 4);
                end
            end
        end
        drain();
    endtask

    task automatic test_gaps();
        int beats = 0;
        bit other = 0;
        bit seen = 0;
        rvc = 4'b0100; ordyc = 1'b1; rvalid = '1; ordy = 1'b1;
        step("gap_arb");
        rvc = 4'b1111;
        for (int i = 0; i < 60 && !seen; i++) begin
            ordy = (i % 2 == 0);
            rvalid = {1'b1, 1'($urandom), 2'b11};
            step("gap");
            if (rvalid[2] && last_rready[2]) beats++;
            if ((last_rready & 4'b1011) != 0) other = 1;
            seen = last_done;
        end
        checks++;
        if (!seen || beats != 4 || other) begin
            errors++;
            $display("FAIL gaps done %b beats %0d other_ready %b required 1 4 0",
                     seen, beats, other);
        end
    endtask

    task automatic test_hold_off();
        bit any = 0;
        rvc = '1; ordyc = 1'b0; rvalid = '1; ordy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("hold");
            any |= last_busy;
        end
        checks++;
        if (any) begin
            errors++;
            $display("FAIL hold_busy got 1 required 0");
        end
        ordyc = 1'b1;
        step("hold_arb");
        step("hold_xfer");
        checks++;
        if (last_grant !== 2'd3 || last_busy !== 1'b1) begin
            errors++;
            $display("FAIL hold_grant grant %0d busy %b required 3 1", last_grant, last_busy);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 500; i++) begin
            rvalid = 4'($urandom);
            rvc    = 4'($urandom);
            ordy   = ($urandom % 4) != 0;
            ordyc  = ($urandom % 3) != 0;
            step("random");
        end
        drain();
    endtask

    task automatic chk3(input string tag, input logic b, input logic [1:0] g,
                        input logic d, input logic [7:0] dat);
        checks++;
        if (busy3 !== b || grant3 !== g || done3 !== d || (b && odata3 !== dat)) begin
            errors++;
            $display("FAIL %s busy %b grant %0d done %b data %h required %b %0d %b %h",
                     tag, busy3, grant3, done3, odata3, b, g, d, dat);
        end
    endtask

    task automatic test_wrap3();
        rdata3 = {8'h22, 8'h11, 8'h00};
        rvalid3 = '1; ordy3 = 1'b1; ordyc3 = 1'b1; rvc3 = 3'b100;
        @(posedge clk); #2;
        chk3("n3_grant2", 1'b1, 2'd2, 1'b1, 8'h22);
        checks++;
        if (rready3 !== 3'b100) begin
            errors++;
            $display("FAIL n3_ready got %b required 100", rready3);
        end
        rvc3 = 3'b011;
        @(posedge clk); #2;
        chk3("n3_idle", 1'b0, 2'd2, 1'b0, 8'h00);
        @(posedge clk); #2;
        chk3("n3_wrap0", 1'b1, 2'd0, 1'b1, 8'h00);
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk3("n3_next1", 1'b1, 2'd1, 1'b1, 8'h11);
        rvc3 = '0;
        @(posedge clk); #2;
        @(posedge clk); #1;
    endtask

    task automatic test_async_reset();
        int n = 0;
        rvalid = '1; rvc = '1; ordy = 1'b1; ordyc = 1'b1;
        while (!(m_busy && m_cnt >= 2) && n < 20) begin
            step("pre_rst");
            n++;
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 0 || rready !== 0 || ovalid !== 0 || done !== 0 || grant !== 0 ||
            busy3 !== 0 || grant3 !== 0 || rready3 !== 0) begin
            errors++;
            $display("FAIL async_reset busy %b rdy %b vld %b done %b grant %0d grant3 %0d required zeros",
                     busy, rready, ovalid, done, grant, grant3);
        end
        m_busy = 0; m_ptr = 0; m_g = 0; m_cnt = 0;
        for (int k = 0; k < N; k++) chunks[k] = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        rvc = 4'b1010;
        step("post_rst");
        step("post_rst");
        checks++;
        if (last_grant !== 2'd1) begin
            errors++;
            $display("FAIL post_reset_grant got %0d required 1", last_grant);
        end
        for (int i = 0; i < 200; i++) begin
            rvalid = 4'($urandom);
            rvc    = 4'($urandom);
            ordy   = ($urandom % 4) != 0;
            ordyc  = ($urandom % 3) != 0;
            step("random2");
        end
        drain();
    endtask

`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
    task automatic test_stats();
        int got = 0;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (stats[k*32 +: 32] !== 32'(chunks[k])) begin
                errors++;
                $display("FAIL stats%0d got %0d required %0d", k, stats[k*32 +: 32], chunks[k]);
            end
        end
        force dut.stats_q[1] = 32'hFFFF_FFFE;
        @(posedge clk);
        #1;
        release dut.stats_q[1];
        rvc = 4'b0010; rvalid = '1; ordy = 1'b1; ordyc = 1'b1;
        for (int i = 0; i < 30 && got < 2; i++) begin
            step("sat");
            if (last_done) got++;
        end
        drain();
        checks++;
        if (stats[63:32] !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL stats_saturate got %h required ffffffff", stats[63:32]);
        end
    endtask
`endif

    initial begin
        for (int k = 0; k < N; k++) begin
            seq[k] = 0;
            chunks[k] = 0;
        end
        rdata = '0; rvalid = '0; rvc = '0; ordy = 1'b0; ordyc = 1'b0;
        rdata3 = '0; rvalid3 = '0; rvc3 = '0; ordy3 = 1'b0; ordyc3 = 1'b0;
        repeat (3) @(posedge clk);
        test_reset();
        test_round_robin();
        test_gaps();
        test_hold_off();
        test_random();
        test_wrap3();
        test_async_reset();
`ifdef MAKESTUFF_CHUNK_ARBITER_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
